// File: rtl/stepper_phase_sequencer_if.sv
// Move-command channel between the curtain controller and the phase sequencer.
// Latency: wires only, no storage.
// Backpressure: cmd_ready from the sequencer qualifies cmd_valid from the controller.
interface stepper_phase_sequencer_if #(
  parameter int STEP_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_abort;

  // Curtain control side: issues commands and aborts.
  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_abort,
    input  cmd_ready
  );

  // Sequencer side: consumes commands.
  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_phase_sequencer.sv
// Stepper coil sequencer: executes move commands one step per tick, tracks absolute position.
// Latency: all outputs registered; new phase/pos/done appear one clk after the causing tick or command.
// Backpressure: cmd_ready low while stepping (RUN); commands accepted in IDLE and HOLD.
module stepper_phase_sequencer #(
  parameter int STEP_W     = 16,
  parameter int POS_W      = 16,
  parameter int HALF_STEP  = 1,
  parameter int HOLD_TICKS = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  stepper_phase_sequencer_if.slave cmd_if,
  output logic [3:0]               phase,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [POS_W-1:0]         pos
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [2:0] IDX_MAX   = (HALF_STEP != 0) ? 3'd7 : 3'd3;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt, idx_step;
  logic [POS_W-1:0]  pos_nxt;
  logic [STEP_W-1:0] rem, rem_nxt;
  logic [7:0]        hold_cnt, hold_nxt;
  logic              dir, dir_nxt;
  logic              ready, ready_nxt;
  logic [3:0]        phase_nxt;
  logic              busy_nxt, done_nxt, aborted_nxt;
  logic              accept, cmd_zero;

  // Coil pattern for a table index; full-step mode only ever uses indices 0..3.
  function automatic logic [3:0] pattern(input logic [2:0] i);
    logic [3:0] p;
    if (HALF_STEP != 0) begin
      case (i)
        3'd0:    p = 4'b0001;
        3'd1:    p = 4'b0011;
        3'd2:    p = 4'b0010;
        3'd3:    p = 4'b0110;
        3'd4:    p = 4'b0100;
        3'd5:    p = 4'b1100;
        3'd6:    p = 4'b1000;
        default: p = 4'b1001;
      endcase
    end else begin
      case (i[1:0])
        2'd0:    p = 4'b0011;
        2'd1:    p = 4'b0110;
        2'd2:    p = 4'b1100;
        default: p = 4'b1001;
      endcase
    end
    return p;
  endfunction

  assign cmd_if.cmd_ready = ready;
  assign accept           = cmd_if.cmd_valid && ready;
  assign cmd_zero         = (cmd_if.cmd_steps == '0);
  assign idx_step = dir ? ((idx == IDX_MAX) ? 3'd0 : idx + 3'd1)
                        : ((idx == 3'd0) ? IDX_MAX : idx - 3'd1);

  // Next-state and next-output decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pos_nxt     = pos;
    rem_nxt     = rem;
    hold_nxt    = hold_cnt;
    dir_nxt     = dir;
    ready_nxt   = ready;
    phase_nxt   = phase;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        phase_nxt = 4'b0000;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
        if (accept) begin
          dir_nxt = cmd_if.cmd_dir;
          rem_nxt = cmd_if.cmd_steps;
          if (cmd_zero) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            phase_nxt = pattern(idx);
            busy_nxt  = 1'b1;
            ready_nxt = 1'b0;
          end
        end
      end
      RUN: begin
        busy_nxt  = 1'b1;
        ready_nxt = 1'b0;
        // Abort beats a coincident tick: no further step is taken.
        if (cmd_if.cmd_abort) begin
          state_nxt   = HOLD;
          hold_nxt    = HOLD_LOAD;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
          ready_nxt   = 1'b1;
        end else if (tick) begin
          idx_nxt   = idx_step;
          phase_nxt = pattern(idx_step);
          pos_nxt   = dir ? pos + POS_W'(1) : pos - POS_W'(1);
          rem_nxt   = rem - STEP_W'(1);
          if (rem == STEP_W'(1)) begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_LOAD;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        busy_nxt  = 1'b1;
        ready_nxt = 1'b1;
        if (accept && !cmd_zero) begin
          // Coils stay on the current pattern, so motion resumes without a gap.
          state_nxt = RUN;
          dir_nxt   = cmd_if.cmd_dir;
          rem_nxt   = cmd_if.cmd_steps;
          hold_nxt  = 8'd0;
          ready_nxt = 1'b0;
        end else begin
          if (accept) begin
            rem_nxt  = cmd_if.cmd_steps;
            done_nxt = 1'b1;
          end
          if (tick) begin
            if (hold_cnt == 8'd1) begin
              state_nxt = IDLE;
              hold_nxt  = 8'd0;
              phase_nxt = 4'b0000;
              busy_nxt  = 1'b0;
            end else begin
              hold_nxt = hold_cnt - 8'd1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 4'b0000;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset de-energises the coils immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      pos      <= '0;
      rem      <= '0;
      hold_cnt <= 8'd0;
      dir      <= 1'b0;
      ready    <= 1'b1;
      phase    <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pos      <= pos_nxt;
      rem      <= rem_nxt;
      hold_cnt <= hold_nxt;
      dir      <= dir_nxt;
      ready    <= ready_nxt;
      phase    <= phase_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      aborted  <= aborted_nxt;
    end
  end

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Self-checking bench: a half-step and a full-step instance share one stimulus stream.
// Outputs are compared every cycle against a behavioural model; literal expectations pin it.
// Stimulus: directed scenarios followed by randomized commands, ticks and aborts.
module tb_stepper_phase_sequencer;
  localparam int STEP_W = 16;
  localparam int POS_W  = 16;
  localparam int HT0    = 50;
  localparam int HT1    = 5;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_dir = 1'b0;
  logic              cmd_abort = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;

  logic [3:0]        ph   [2];
  logic              bsy  [2];
  logic              dn   [2];
  logic              abt  [2];
  logic              rdy  [2];
  logic [POS_W-1:0]  ps   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stepper_phase_sequencer_if #(.STEP_W(STEP_W)) if0();
  stepper_phase_sequencer_if #(.STEP_W(STEP_W)) if1();

  assign if0.cmd_valid = cmd_valid;
  assign if0.cmd_dir   = cmd_dir;
  assign if0.cmd_steps = cmd_steps;
  assign if0.cmd_abort = cmd_abort;
  assign if1.cmd_valid = cmd_valid;
  assign if1.cmd_dir   = cmd_dir;
  assign if1.cmd_steps = cmd_steps;
  assign if1.cmd_abort = cmd_abort;
  assign rdy[0] = if0.cmd_ready;
  assign rdy[1] = if1.cmd_ready;

  stepper_phase_sequencer #(.STEP_W(STEP_W), .POS_W(POS_W), .HALF_STEP(1), .HOLD_TICKS(HT0)) dut_half (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cmd_if(if0),
    .phase(ph[0]), .busy(bsy[0]), .done(dn[0]), .aborted(abt[0]), .pos(ps[0])
  );

  stepper_phase_sequencer #(.STEP_W(STEP_W), .POS_W(POS_W), .HALF_STEP(0), .HOLD_TICKS(HT1)) dut_full (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cmd_if(if1),
    .phase(ph[1]), .busy(bsy[1]), .done(dn[1]), .aborted(abt[1]), .pos(ps[1])
  );

  // Behavioural model: motion mode, unbounded table index, position, steps left, hold ticks left.
  logic [3:0] tbl_half [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
  logic [3:0] tbl_full [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
  int tlen   [2] = '{8, 4};
  int hticks [2] = '{HT0, HT1};
  int m_mode [2];
  int m_idx  [2];
  int m_pos  [2];
  int m_rem  [2];
  int m_hold [2];
  bit m_dir  [2];
  bit m_done [2];
  bit m_abt  [2];

  function automatic logic [3:0] exp_phase(input int k);
    int r;
    if (m_mode[k] == M_IDLE) return 4'b0000;
    r = ((m_idx[k] % tlen[k]) + tlen[k]) % tlen[k];
    return (k == 0) ? tbl_half[r] : tbl_full[r];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_idx[k] = 0; m_pos[k] = 0; m_rem[k] = 0;
      m_hold[k] = 0; m_dir[k] = 1'b0; m_done[k] = 1'b0; m_abt[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit acc;
    int step;
    acc = cmd_valid && (m_mode[k] != M_RUN);
    m_done[k] = 1'b0;
    m_abt[k]  = 1'b0;
    if (m_mode[k] == M_RUN) begin
      if (cmd_abort) begin
        m_mode[k] = M_HOLD; m_hold[k] = hticks[k]; m_done[k] = 1'b1; m_abt[k] = 1'b1;
      end else if (tick) begin
        step = m_dir[k] ? 1 : -1;
        m_idx[k] += step;
        m_pos[k] = (m_pos[k] + step) & 32'hFFFF;
        m_rem[k] -= 1;
        if (m_rem[k] == 0) begin
          m_mode[k] = M_HOLD; m_hold[k] = hticks[k]; m_done[k] = 1'b1;
        end
      end
    end else if (acc && cmd_steps != 0) begin
      m_mode[k] = M_RUN; m_dir[k] = cmd_dir; m_rem[k] = int'(cmd_steps);
    end else begin
      if (acc) m_done[k] = 1'b1;
      if (m_mode[k] == M_HOLD && tick) begin
        m_hold[k] -= 1;
        if (m_hold[k] == 0) m_mode[k] = M_IDLE;
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk("phase",   k, 32'(ph[k]),  32'(exp_phase(k)));
      chk("busy",    k, 32'(bsy[k]), 32'(m_mode[k] != M_IDLE));
      chk("ready",   k, 32'(rdy[k]), 32'(m_mode[k] != M_RUN));
      chk("done",    k, 32'(dn[k]),  32'(m_done[k]));
      chk("aborted", k, 32'(abt[k]), 32'(m_abt[k]));
      chk("pos",     k, 32'(ps[k]),  32'(m_pos[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare();
  endtask

  task automatic send(input bit d, input int n);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = STEP_W'(n);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (gap) cycle();
    end
  endtask

  logic [3:0] t1h [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
  logic [3:0] t1f [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
  logic [3:0] t2h [6] = '{4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
  logic [3:0] t2f [6] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};

  initial begin
    int vrate;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_phase", 0, 32'(ph[0]), 32'h0);
    chk("rst_ready", 0, 32'(rdy[0]), 32'h1);
    chk("rst_pos",   1, 32'(ps[1]), 32'h0);
    compare();
    rst_n = 1'b1;
    cycle();

    // Forward 3 half-steps / full-steps from index 0, ticks every 8 cycles.
    send(1'b1, 3);
    chk("t1_entry", 0, 32'(ph[0]), 32'(t1h[0]));
    chk("t1_entry", 1, 32'(ph[1]), 32'(t1f[0]));
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      chk("t1_phase", 0, 32'(ph[0]), 32'(t1h[i+1]));
      chk("t1_phase", 1, 32'(ph[1]), 32'(t1f[i+1]));
      if (i == 2) chk("t1_done", 0, 32'(dn[0]), 32'h1);
      repeat (7) cycle();
    end
    chk("t1_pos", 0, 32'(ps[0]), 32'h3);
    ticks(49, 1);
    chk("t1_hold", 0, 32'(ph[0]), 32'b0110);
    ticks(1, 1);
    chk("t1_off_phase", 0, 32'(ph[0]), 32'h0);
    chk("t1_off_busy",  0, 32'(bsy[0]), 32'h0);

    // Reverse 5 steps through the index wrap and position underflow.
    send(1'b0, 5);
    chk("t2_entry", 0, 32'(ph[0]), 32'(t2h[0]));
    chk("t2_entry", 1, 32'(ph[1]), 32'(t2f[0]));
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      chk("t2_phase", 0, 32'(ph[0]), 32'(t2h[i+1]));
      chk("t2_phase", 1, 32'(ph[1]), 32'(t2f[i+1]));
      cycle();
    end
    chk("t2_pos", 0, 32'(ps[0]), 32'hFFFE);
    chk("t2_pos", 1, 32'(ps[1]), 32'hFFFE);
    ticks(50, 1);

    // Abort coincident with tick 11 of a 100-step move.
    send(1'b1, 100);
    ticks(10, 1);
    tick = 1'b1; cmd_abort = 1'b1;
    cycle();
    tick = 1'b0; cmd_abort = 1'b0;
    chk("ab_done",  0, 32'(dn[0]), 32'h1);
    chk("ab_flag",  0, 32'(abt[0]), 32'h1);
    chk("ab_pos",   0, 32'(ps[0]), 32'h0008);
    chk("ab_phase", 0, 32'(ph[0]), 32'b0001);
    chk("ab_phase", 1, 32'(ph[1]), 32'b0011);
    cycle();
    chk("ab_done_end", 0, 32'(dn[0]), 32'h0);
    chk("ab_flag_end", 0, 32'(abt[0]), 32'h0);

    // New command issued partway through the hold period.
    ticks(19, 1);
    chk("hold_on", 0, 32'(bsy[0]), 32'h1);
    send(1'b1, 2);
    chk("rehold_phase", 0, 32'(ph[0]), 32'b0001);
    chk("rehold_ready", 0, 32'(rdy[0]), 32'h0);
    ticks(2, 1);
    chk("rehold_pos", 0, 32'(ps[0]), 32'h000A);
    chk("rehold_ph",  0, 32'(ph[0]), 32'b0010);
    ticks(50, 1);

    // Zero-step command in IDLE.
    send(1'b1, 0);
    chk("zero_done", 0, 32'(dn[0]), 32'h1);
    chk("zero_busy", 0, 32'(bsy[0]), 32'h0);
    chk("zero_pos",  0, 32'(ps[0]), 32'h000A);
    cycle();

    // Randomized traffic in segments of differing command density.
    for (int seg = 0; seg < 8; seg++) begin
      vrate = (seg % 2 == 1) ? 7 : 199;
      for (int c = 0; c < 500; c++) begin
        tick      = ($urandom_range(0, 2) == 0);
        cmd_valid = ($urandom_range(0, vrate) == 0);
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_steps = ($urandom_range(0, 9) == 0) ? '0 : STEP_W'($urandom_range(1, 12));
        cmd_abort = ($urandom_range(0, 39) == 0);
        cycle();
      end
    end
    tick = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0;
    ticks(60, 0);

    // Asynchronous reset in the middle of a move.
    send(1'b1, 100);
    ticks(3, 1);
    chk("pre_rst_busy", 0, 32'(bsy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", 0, 32'(ph[0]), 32'h0);
    chk("arst_phase", 1, 32'(ph[1]), 32'h0);
    chk("arst_pos",   0, 32'(ps[0]), 32'h0);
    chk("arst_busy",  0, 32'(bsy[0]), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) cycle();
    send(1'b1, 1);
    ticks(1, 1);
    chk("post_rst_ph", 0, 32'(ph[0]), 32'b0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
